// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Number of whole cycles the divided output spends high for ratio n.
    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/freq_div_ctrl_half_cycle_ext.sv
// Stretches the posedge-generated high phase by half a cycle for odd ratios.
module half_cycle_ext (
    input  logic clk,
    input  logic rst_n,
    input  logic p_q,
    input  logic odd,
    output logic freq_out
);

    logic r_n;

    // Falling-edge copy of p_q; holds the output high through the first half
    // of the cycle after p_q drops.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= 1'b0;
        end else begin
            r_n <= p_q;
        end
    end

    assign freq_out = p_q | (r_n & odd);

endmodule

// File: rtl/freq_div_ctrl.sv
// Divide-by-N controller: run/stop sequencing, period counter, shadowed
// ratio reconfiguration and 50%-duty output generation.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         freq_out,
    output logic         tick,
    output logic         running,
    output logic [W-1:0] cur_div
);

    state_t       r_state;
    state_t       w_state_d;
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_d;
    logic [W-1:0] r_cur_div;
    logic [W-1:0] w_div_d;
    logic [W-1:0] r_shadow;
    logic         r_shadow_vld;
    logic         w_shadow_clr;
    logic         w_accept;
    logic         w_legal;
    logic         w_boundary;
    logic [W-1:0] w_half_d;
    logic         r_p;
    logic         r_tick;
    logic         r_running;
    logic         r_err;

    // Next state, count and ratio; a pending shadow ratio only takes effect
    // when leaving IDLE-time or at the end of a period.
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_div_d      = r_cur_div;
        w_shadow_clr = 1'b0;
        w_accept     = cfg_valid && !r_shadow_vld;
        w_legal      = cfg_div >= W'(MIN_DIV);
        w_boundary   = (r_state != IDLE) && (r_cnt == r_cur_div - W'(1));
        unique case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (r_shadow_vld) begin
                    w_div_d      = r_shadow;
                    w_shadow_clr = 1'b1;
                end
                if (en) begin
                    w_state_d = RUN;
                end
            end
            RUN, STOP: begin
                if (w_boundary) begin
                    w_cnt_d   = '0;
                    w_state_d = en ? RUN : IDLE;
                    if (r_shadow_vld) begin
                        w_div_d      = r_shadow;
                        w_shadow_clr = 1'b1;
                    end
                end else begin
                    w_cnt_d   = r_cnt + W'(1);
                    w_state_d = en ? RUN : STOP;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
        w_half_d = W'(half(32'(w_div_d)));
    end

    // Sequencer state plus outputs registered from the next-state values so
    // each output reflects the cycle it is observed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cur_div    <= W'(DEFAULT_DIV);
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_p          <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_cur_div <= w_div_d;
            r_err     <= w_accept && !w_legal;
            if (w_shadow_clr) begin
                r_shadow_vld <= 1'b0;
            end else if (w_accept && w_legal) begin
                r_shadow_vld <= 1'b1;
                r_shadow     <= cfg_div;
            end
            r_running <= (w_state_d != IDLE);
            r_tick    <= (w_state_d != IDLE) && (w_cnt_d == w_div_d - W'(1));
            r_p       <= (w_state_d != IDLE) && (w_cnt_d < w_half_d);
        end
    end

    half_cycle_ext u_half_cycle_ext (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_q      (r_p),
        .odd      (r_cur_div[0]),
        .freq_out (freq_out)
    );

    assign cfg_ready = !r_shadow_vld;
    assign cfg_err   = r_err;
    assign tick      = r_tick;
    assign running   = r_running;
    assign cur_div   = r_cur_div;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_freq_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       freq_out;
    logic       tick;
    logic       running;
    logic [7:0] cur_div;

    int n_cmp = 0;
    int n_bad = 0;

    freq_div_ctrl #(.W(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .freq_out  (freq_out),
        .tick      (tick),
        .running   (running),
        .cur_div   (cur_div)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=stop; pos = position in period.
    int m_mode;
    int m_pos;
    int m_div;
    bit m_pend;
    int m_pend_val;
    bit m_err;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_div = 3; m_pend = 0; m_pend_val = 0; m_err = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit last;
        bit acc;
        bit apply;
        last  = (m_mode != 0) && (m_pos == m_div - 1);
        acc   = v && !m_pend;
        apply = m_pend && ((m_mode == 0) || last);
        m_err = acc && (d < 2);
        if (m_mode == 0) begin
            m_pos = 0;
            if (e) m_mode = 1;
        end else if (last) begin
            m_pos  = 0;
            m_mode = e ? 1 : 0;
        end else begin
            m_pos  = m_pos + 1;
            m_mode = e ? 1 : 2;
        end
        if (apply) begin
            m_div  = m_pend_val;
            m_pend = 0;
        end
        if (acc && d >= 2) begin
            m_pend     = 1;
            m_pend_val = d;
        end
    endtask

    function automatic bit exp_hi_first();
        int h;
        h = m_div / 2;
        return (m_mode != 0) && ((m_pos < h) || ((m_div % 2 == 1) && (m_pos == h)));
    endfunction

    function automatic bit exp_hi_second();
        return (m_mode != 0) && (m_pos < m_div / 2);
    endfunction

    // One model-checked clock cycle with the given inputs.
    task automatic cyc(input bit e, input bit v, input int d);
        en = e; cfg_valid = v; cfg_div = 8'(d);
        @(posedge clk);
        model_step(e, v, d);
        #1;
        chk("tick", int'(tick), int'((m_mode != 0) && (m_pos == m_div - 1)));
        chk("running", int'(running), int'(m_mode != 0));
        chk("cur_div", int'(cur_div), m_div);
        chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        chk("freq_out_first_half", int'(freq_out), int'(exp_hi_first()));
        @(negedge clk);
        #1;
        chk("freq_out_second_half", int'(freq_out), int'(exp_hi_second()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #2;
        chk("rst_freq_out", int'(freq_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cur_div", int'(cur_div), 3);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    typedef struct {
        bit en; bit v; int d;
        bit f1; bit f2; bit tk; bit run; int div; bit rdy; bit err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();

        // Default N=3 run, illegal ratio, then N=5 accepted and applied via STOP->IDLE.
        tbl[0]  = '{1, 0, 0, 1, 1, 0, 1, 3, 1, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 1, 3, 1, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 1, 1, 3, 1, 1};
        tbl[3]  = '{1, 0, 0, 1, 1, 0, 1, 3, 1, 0};
        tbl[4]  = '{1, 1, 5, 1, 0, 0, 1, 3, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 3, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 0};
        tbl[7]  = '{1, 0, 0, 1, 1, 0, 1, 5, 1, 0};
        tbl[8]  = '{1, 0, 0, 1, 1, 0, 1, 5, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 0, 0, 1, 5, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 5, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 1, 1, 5, 1, 0};
        tbl[12] = '{1, 0, 0, 1, 1, 0, 1, 5, 1, 0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en; cfg_valid = tbl[i].v; cfg_div = 8'(tbl[i].d);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_freq_first", i), int'(freq_out), int'(tbl[i].f1));
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].tk));
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].run));
            chk($sformatf("vec%0d_cur_div", i), int'(cur_div), tbl[i].div);
            chk($sformatf("vec%0d_cfg_ready", i), int'(cfg_ready), int'(tbl[i].rdy));
            chk($sformatf("vec%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].err));
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_freq_second", i), int'(freq_out), int'(tbl[i].f2));
        end

        // Configure N=4 while idle, then run.
        do_reset();
        cyc(0, 1, 4);
        cyc(0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0);

        // Running N=3, accept N=5 at cnt=1.
        do_reset();
        cyc(1, 0, 0);
        cyc(1, 1, 5);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);

        // N=6: drop en at cnt=1, re-assert during STOP, later stop for good.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
        cyc(0, 1, 6);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);

        // Accept on a boundary cycle, then en falls on a boundary cycle.
        cyc(1, 0, 0);
        for (int i = 0; i < 20 && !((m_mode != 0) && (m_pos == m_div - 1)); i++) cyc(1, 0, 0);
        chk("reach_boundary", int'((m_mode != 0) && (m_pos == m_div - 1)), 1);
        cyc(1, 1, 2);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0);
        for (int i = 0; i < 20 && !((m_mode != 0) && (m_pos == m_div - 1)); i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Async reset mid-high-phase with a pending shadow ratio.
        do_reset();
        cyc(1, 0, 0);
        en = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd7;
        @(posedge clk);
        model_step(1, 1, 7);
        #1;
        chk("pre_rst_freq_out", int'(freq_out), 1);
        chk("pre_rst_cfg_ready", int'(cfg_ready), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_freq_out", int'(freq_out), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        chk("midrst_cur_div", int'(cur_div), 3);
        en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 7; i++) cyc(1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit e;
            bit v;
            int d;
            int sel;
            e   = ($urandom_range(0, 9) < 8);
            v   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            if (sel == 0) d = $urandom_range(0, 1);
            else if (sel == 1) d = $urandom_range(2, 9);
            else d = $urandom_range(2, 40);
            cyc(e, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
